mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single synchronous-read RAM between the CPU controller's memory path (port 0) and the program loader/debug port (port 1). It serialises their requests with round-robin fairness, drives the RAM address, write-enable and write-data, and returns read data with a valid strobe. It sits between the requesters and the RAM, replacing any direct requester-to-RAM wiring.

## Interface
- AW, 8, address width in bits
- DW, 16, data width in bits

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  2  request per port; bit 0 = CPU, bit 1 = loader
- we  in  2  per-port write flag, 1 = write, 0 = read; valid while req high
- addr  in  2*AW  per-port address; port p occupies bits [p*AW +: AW]
- wdata  in  2*DW  per-port write data; port p occupies bits [p*DW +: DW]
- gnt  out  2  one-hot, one-cycle grant pulse; request consumed
- rvalid  out  2  one-hot, one-cycle read-data-valid pulse
- rdata  out  DW  read data, shared by both ports; meaningful only while some rvalid bit is high
- busy  out  1  high in any state other than IDLE
- mem_addr  out  AW  RAM address
- mem_write  out  1  RAM write enable
- mem_din  out  DW  RAM write data
- mem_dout  in  DW  RAM read data, valid one cycle after the address is presented

## Operation
- States: IDLE, ACCESS, READ.
- IDLE: if req == 0, stay. Otherwise pick a winner w. Single requester wins outright. If both request, w = !last. On this edge, latch we[w], addr[w] and wdata[w] into internal registers, set last = w, and go to ACCESS.
- ACCESS, one cycle:
  - mem_addr = latched addr; mem_din = latched wdata; mem_write = latched we.
  - gnt[w] = 1.
  - If write: RAM writes on the edge ending ACCESS, then go to IDLE.
  - If read: go to READ.
- READ, one cycle: rvalid[w] = 1, rdata = mem_dout. Then go to IDLE.
- mem_write is 0 in every state other than ACCESS. mem_addr and mem_din hold their last values outside ACCESS.
- Requester contract:
  - Hold req, we, addr and wdata stable from assertion until gnt is sampled high.
  - Deassert req on the edge where gnt is sampled high, unless issuing a new request.
  - Inputs are don't-care after the latch edge.
- req for a port may rise while the other port's transaction is in flight. It is served in the next IDLE cycle.
- Round-robin is strict:
  - With both ports continuously requesting, grants alternate 0,1,0,1…
  - A lone requester may be granted back-to-back with no penalty.
- last resets to 1, so the CPU wins the first tie.
- No address or width checks. addr is used modulo 2^AW by the RAM.

## Timing
- Reset (reset = 0, asynchronous):
  - state = IDLE; last = 1.
  - gnt = 0, rvalid = 0, busy = 0, mem_write = 0, mem_addr = 0, mem_din = 0, rdata = 0.
  - Latched registers are cleared.
  - Reset asserted during ACCESS drops mem_write immediately, so no RAM write occurs at the following edge.
  - Reset during READ suppresses rvalid.
  - After reset release, the first req is sampled at the next rising edge.
- Write latency: req sampled at edge E0 → gnt high during cycle E0..E1 → RAM written at E1 → IDLE at E1. Minimum spacing is 2 cycles per write.
- Read latency: req sampled at E0 → gnt during E0..E1 → rvalid and rdata during E1..E2 → IDLE at E2. Minimum spacing is 3 cycles per read.
- gnt and rvalid are never high in the same cycle and are never high for more than one cycle per transaction.
- busy is high exactly during ACCESS and READ.
- Simultaneous req in IDLE: exactly one grant, chosen by last. The loser keeps req high and is granted in the next IDLE.
- A req asserted in the same cycle the arbiter enters IDLE is sampled at the end of that IDLE cycle. No request is lost or duplicated.

## Test plan
- Single CPU write: req = 01, we = 01, addr0 = 0x10, wdata0 = 0xBEEF.
  - Next cycle: gnt = 01, mem_write = 1, mem_addr = 0x10, mem_din = 0xBEEF.
  - Then IDLE; RAM[0x10] = 0xBEEF.
- Loader read of RAM[0x10] = 0xBEEF: req = 10, we = 00, addr1 = 0x10.
  - gnt = 10 one cycle after req is sampled.
  - Next cycle: rvalid = 10, rdata = 0xBEEF.
  - busy high for exactly 2 cycles.
- Both ports requesting reads continuously from reset: grant sequence 01,10,01,10. Each rvalid matches the preceding gnt and returns that port's address contents.
- Back-to-back CPU writes to 0x00..0x03 with loader idle: 4 gnt pulses spaced 2 cycles apart; RAM holds all 4 values.
- Reset mid-operation:
  - Assert reset during ACCESS of a write to 0x20 (prior value 0x1234): outputs drop immediately; RAM[0x20] stays 0x1234; state = IDLE.
  - Assert reset during READ: rvalid never pulses.
- Late arrival: loader raises req during a CPU read's READ cycle. Loader is granted in the cycle after the following IDLE, with no lost or duplicated grant.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single synchronous-read RAM.
// Port 0 is the CPU memory path and port 1 is the loader/debug port.
module mem_arbiter #(
   parameter int AW = 8,
   parameter int DW = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [1:0]      req,
   input  logic [1:0]      we,
   input  logic [2*AW-1:0] addr,
   input  logic [2*DW-1:0] wdata,
   output logic [1:0]      gnt,
   output logic [1:0]      rvalid,
   output logic [DW-1:0]   rdata,
   output logic            busy,
   output logic [AW-1:0]   mem_addr,
   output logic            mem_write,
   output logic [DW-1:0]   mem_din,
   input  logic [DW-1:0]   mem_dout
);

   typedef enum logic [1:0] {IDLE, ACCESS, READ} state_t;

   state_t        state_q;
   logic          last_q;
   logic          win_q;
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [1:0]    gnt_q;
   logic [1:0]    rvalid_q;
   logic          busy_q;
   logic          mem_write_q;

   logic          win_d;
   logic [AW-1:0] addr_d;
   logic [DW-1:0] wdata_d;

   // A lone requester wins outright; on a tie the port that did not win last time goes.
   always_comb begin
      win_d   = req[1] & (~req[0] | ~last_q);
      addr_d  = win_d ? addr[2*AW-1:AW]  : addr[AW-1:0];
      wdata_d = win_d ? wdata[2*DW-1:DW] : wdata[DW-1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         win_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         gnt_q       <= '0;
         rvalid_q    <= '0;
         busy_q      <= 1'b0;
         mem_write_q <= 1'b0;
      end else begin
         gnt_q       <= '0;
         rvalid_q    <= '0;
         mem_write_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (|req) begin
                  win_q       <= win_d;
                  last_q      <= win_d;
                  we_q        <= we[win_d];
                  addr_q      <= addr_d;
                  wdata_q     <= wdata_d;
                  gnt_q       <= {win_d, ~win_d};
                  mem_write_q <= we[win_d];
                  busy_q      <= 1'b1;
                  state_q     <= ACCESS;
               end
            end
            ACCESS: begin
               // The RAM commits a write on this edge; a read needs one more cycle for data.
               if (we_q) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  rvalid_q <= {win_q, ~win_q};
                  state_q  <= READ;
               end
            end
            READ: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign rvalid    = rvalid_q;
   assign busy      = busy_q;
   assign mem_addr  = addr_q;
   assign mem_din   = wdata_q;
   assign mem_write = mem_write_q;
   // RAM output is only valid in READ; hold zero otherwise so reset leaves rdata clean.
   assign rdata     = (|rvalid_q) ? mem_dout : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-timeline reference model.
module tb_mem_arbiter;
   localparam int AW = 8;
   localparam int DW = 16;

   logic            clk = 1'b0;
   logic            reset;
   logic [1:0]      req, we;
   logic [2*AW-1:0] addr;
   logic [2*DW-1:0] wdata;
   logic [1:0]      gnt, rvalid;
   logic [DW-1:0]   rdata, mem_din, mem_dout;
   logic            busy, mem_write;
   logic [AW-1:0]   mem_addr;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
      .mem_addr(mem_addr), .mem_write(mem_write), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   // Synchronous-read RAM; never-written words read back a fixed address pattern.
   logic [DW-1:0] ram [256];
   logic [255:0]  ram_vld;
   logic          ram_clr;

   function automatic logic [DW-1:0] ram_init(input logic [AW-1:0] a);
      return {a, ~a};
   endfunction

   function automatic logic [DW-1:0] ram_peek(input logic [AW-1:0] a);
      return ram_vld[a] ? ram[a] : ram_init(a);
   endfunction

   always @(posedge clk) begin
      if (ram_clr) ram_vld <= '0;
      else if (mem_write) begin
         ram[mem_addr]     <= mem_din;
         ram_vld[mem_addr] <= 1'b1;
      end
      mem_dout <= ram_vld[mem_addr] ? ram[mem_addr] : ram_init(mem_addr);
   end

   // Reference model: a schedule of expected per-cycle outputs, filled when a grant is decided.
   typedef struct packed {
      logic [1:0]    gnt;
      logic [1:0]    rvalid;
      logic          busy;
      logic          mw;
      logic [DW-1:0] rd;
   } exp_t;

   exp_t          exp_q [3];
   logic [DW-1:0] mdl_mem [256];
   logic          mdl_last;
   int            busy_left;
   logic [AW-1:0] held_a, wr_a;
   logic [DW-1:0] held_d, wr_d;
   logic          pend_wr;
   int            cyc;

   task automatic model_reset();
      mdl_last  = 1'b1;
      busy_left = 0;
      held_a    = '0;
      held_d    = '0;
      pend_wr   = 1'b0;
      for (int i = 0; i < 3; i++) exp_q[i] = '0;
   endtask

   // One clock: decide on the currently driven requests, advance, check at the negedge.
   task automatic tick();
      logic w;
      exp_t e;
      if (busy_left == 0 && req != 2'b00) begin
         w        = (req == 2'b11) ? ~mdl_last : req[1];
         mdl_last = w;
         held_a   = w ? addr[2*AW-1:AW]  : addr[AW-1:0];
         held_d   = w ? wdata[2*DW-1:DW] : wdata[DW-1:0];
         exp_q[0].gnt  = w ? 2'b10 : 2'b01;
         exp_q[0].busy = 1'b1;
         exp_q[0].mw   = we[w];
         if (we[w]) busy_left = 2;
         else begin
            exp_q[1].rvalid = w ? 2'b10 : 2'b01;
            exp_q[1].busy   = 1'b1;
            exp_q[1].rd     = mdl_mem[held_a];
            busy_left       = 3;
         end
      end
      @(posedge clk);
      if (pend_wr) mdl_mem[wr_a] = wr_d;
      pend_wr = 1'b0;
      @(negedge clk);
      cyc++;
      e = exp_q[0];
      checks++;
      if (gnt !== e.gnt) begin errors++; $display("FAIL model_gnt cyc=%0d got=%b exp=%b", cyc, gnt, e.gnt); end
      checks++;
      if (rvalid !== e.rvalid) begin errors++; $display("FAIL model_rvalid cyc=%0d got=%b exp=%b", cyc, rvalid, e.rvalid); end
      checks++;
      if (busy !== e.busy) begin errors++; $display("FAIL model_busy cyc=%0d got=%b exp=%b", cyc, busy, e.busy); end
      checks++;
      if (mem_write !== e.mw) begin errors++; $display("FAIL model_mem_write cyc=%0d got=%b exp=%b", cyc, mem_write, e.mw); end
      checks++;
      if (mem_addr !== held_a) begin errors++; $display("FAIL model_mem_addr cyc=%0d got=%h exp=%h", cyc, mem_addr, held_a); end
      checks++;
      if (mem_din !== held_d) begin errors++; $display("FAIL model_mem_din cyc=%0d got=%h exp=%h", cyc, mem_din, held_d); end
      if (e.rvalid != 2'b00) begin
         checks++;
         if (rdata !== e.rd) begin errors++; $display("FAIL model_rdata cyc=%0d got=%h exp=%h", cyc, rdata, e.rd); end
      end
      if (e.mw) begin pend_wr = 1'b1; wr_a = held_a; wr_d = held_d; end
      exp_q[0] = exp_q[1];
      exp_q[1] = exp_q[2];
      exp_q[2] = '0;
      if (busy_left > 0) busy_left--;
   endtask

   task automatic test_reset();
      reset = 1'b0; req = '0; we = '0; addr = '0; wdata = '0; ram_clr = 1'b1;
      repeat (3) @(negedge clk);
      ram_clr = 1'b0;
      checks++; if (gnt !== 2'b00)     begin errors++; $display("FAIL rst_gnt got=%b exp=00", gnt); end
      checks++; if (rvalid !== 2'b00)  begin errors++; $display("FAIL rst_rvalid got=%b exp=00", rvalid); end
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_mem_write got=%b exp=0", mem_write); end
      checks++; if (mem_addr !== '0)   begin errors++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
      checks++; if (mem_din !== '0)    begin errors++; $display("FAIL rst_mem_din got=%h exp=0", mem_din); end
      checks++; if (rdata !== '0)      begin errors++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_cpu_write();
      req = 2'b01; we = 2'b01; addr[AW-1:0] = 8'h10; wdata[DW-1:0] = 16'hBEEF;
      tick();
      checks++; if (gnt !== 2'b01)      begin errors++; $display("FAIL wr_gnt got=%b exp=01", gnt); end
      checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL wr_mem_write got=%b exp=1", mem_write); end
      checks++; if (mem_addr !== 8'h10) begin errors++; $display("FAIL wr_mem_addr got=%h exp=10", mem_addr); end
      checks++; if (mem_din !== 16'hBEEF) begin errors++; $display("FAIL wr_mem_din got=%h exp=beef", mem_din); end
      req = 2'b00;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_idle_busy got=%b exp=0", busy); end
      checks++; if (ram_peek(8'h10) !== 16'hBEEF) begin errors++; $display("FAIL wr_ram got=%h exp=beef", ram_peek(8'h10)); end
   endtask

   task automatic test_loader_read();
      int bcount = 0;
      req = 2'b10; we = 2'b00; addr[2*AW-1:AW] = 8'h10;
      tick();
      bcount += int'(busy);
      checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL rd_gnt got=%b exp=10", gnt); end
      req = 2'b00;
      tick();
      bcount += int'(busy);
      checks++; if (rvalid !== 2'b10) begin errors++; $display("FAIL rd_rvalid got=%b exp=10", rvalid); end
      checks++; if (rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_rdata got=%h exp=beef", rdata); end
      tick();
      bcount += int'(busy);
      checks++; if (bcount != 2) begin errors++; $display("FAIL rd_busy_cycles got=%0d exp=2", bcount); end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] vals [4];
      int t_g [4];
      int idx = 0;
      int c = 0;
      for (int i = 0; i < 4; i++) vals[i] = DW'($urandom);
      req = 2'b01; we = 2'b01; addr[AW-1:0] = 8'h00; wdata[DW-1:0] = vals[0];
      while (idx < 4 && c < 20) begin
         tick();
         c++;
         if (gnt[0]) begin
            t_g[idx] = c;
            idx++;
            if (idx < 4) begin addr[AW-1:0] = AW'(idx); wdata[DW-1:0] = vals[idx]; end
            else req = 2'b00;
         end
      end
      checks++;
      if (idx != 4) begin errors++; $display("FAIL b2b_grants got=%0d exp=4", idx); end
      else for (int i = 1; i < 4; i++) begin
         checks++;
         if (t_g[i] - t_g[i-1] != 2) begin
            errors++; $display("FAIL b2b_spacing i=%0d got=%0d exp=2", i, t_g[i] - t_g[i-1]);
         end
      end
      req = 2'b00;
      tick();
      for (int i = 0; i < 4; i++) begin
         req = 2'b01; we = 2'b00; addr[AW-1:0] = AW'(i);
         tick();
         req = 2'b00;
         tick();
         checks++;
         if (rvalid !== 2'b01 || rdata !== vals[i]) begin
            errors++; $display("FAIL b2b_readback a=%0d got=%b/%h exp=01/%h", i, rvalid, rdata, vals[i]);
         end
         tick();
      end
   endtask

   task automatic test_late_arrival();
      int gt = -1;
      int ng = 0;
      req = 2'b01; we = 2'b00; addr[AW-1:0] = 8'h40;
      tick();
      req = 2'b00;
      tick();
      checks++; if (rvalid !== 2'b01) begin errors++; $display("FAIL late_cpu_rvalid got=%b exp=01", rvalid); end
      req[1] = 1'b1; we[1] = 1'b0; addr[2*AW-1:AW] = 8'h10;
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (gnt[1]) begin
            ng++;
            if (gt < 0) gt = k;
            req[1] = 1'b0;
         end
      end
      checks++; if (ng != 1) begin errors++; $display("FAIL late_grant_count got=%0d exp=1", ng); end
      checks++; if (gt != 2) begin errors++; $display("FAIL late_grant_cycle got=%0d exp=2", gt); end
   endtask

   task automatic test_reset_mid();
      req = 2'b01; we = 2'b01; addr[AW-1:0] = 8'h20; wdata[DW-1:0] = 16'h1234;
      tick();
      req = 2'b00;
      tick();
      wdata[DW-1:0] = 16'hDEAD; req = 2'b01;
      tick();
      checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL mid_pre_write got=%b exp=1", mem_write); end
      #2 reset = 1'b0;
      #1;
      checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL mid_mem_write got=%b exp=0", mem_write); end
      checks++; if (gnt !== 2'b00)      begin errors++; $display("FAIL mid_gnt got=%b exp=00", gnt); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL mid_busy got=%b exp=0", busy); end
      checks++; if (mem_addr !== '0)    begin errors++; $display("FAIL mid_mem_addr got=%h exp=0", mem_addr); end
      req = 2'b00;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      checks++; if (ram_peek(8'h20) !== 16'h1234) begin errors++; $display("FAIL mid_ram got=%h exp=1234", ram_peek(8'h20)); end
      // Reset landing in the READ cycle must swallow the data strobe.
      req = 2'b01; we = 2'b00; addr[AW-1:0] = 8'h20;
      tick();
      req = 2'b00;
      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL rdrst_rvalid got=%b exp=00", rvalid); end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checks++; if (rvalid !== 2'b00 || busy !== 1'b0) begin
            errors++; $display("FAIL rdrst_hold got=%b/%b exp=00/0", rvalid, busy);
         end
      end
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_both_reads();
      logic [1:0] seq [$];
      logic [1:0] prev = 2'b00;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      req = 2'b11; we = 2'b00; addr = {8'h31, 8'h30};
      for (int k = 0; k < 12; k++) begin
         tick();
         if (rvalid != 2'b00) begin
            checks++;
            if (rvalid !== prev) begin errors++; $display("FAIL rr_rvalid_port got=%b exp=%b", rvalid, prev); end
         end
         if (gnt != 2'b00) begin seq.push_back(gnt); prev = gnt; end
      end
      checks++;
      if (seq.size() < 4) begin errors++; $display("FAIL rr_count got=%0d exp=4", seq.size()); end
      else for (int i = 0; i < 4; i++) begin
         checks++;
         if (seq[i] !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL rr_order i=%0d got=%b exp=%b", i, seq[i], (i % 2 == 1) ? 2'b10 : 2'b01);
         end
      end
      req = 2'b00;
      repeat (3) tick();
   endtask

   task automatic test_random(input int n);
      int issued [2] = '{0, 0};
      int granted [2] = '{0, 0};
      int k = 0;
      for (int c = 0; c < n; c++) begin
         for (int p = 0; p < 2; p++) begin
            if (!req[p] && $urandom_range(0, 2) == 0) begin
               req[p] = 1'b1;
               we[p]  = 1'($urandom_range(0, 1));
               addr[p*AW +: AW]  = AW'($urandom_range(0, 15));
               wdata[p*DW +: DW] = DW'($urandom);
               issued[p]++;
            end
         end
         tick();
         for (int p = 0; p < 2; p++) if (gnt[p]) begin req[p] = 1'b0; granted[p]++; end
      end
      while ((req != 2'b00 || busy_left != 0) && k < 50) begin
         tick();
         for (int p = 0; p < 2; p++) if (gnt[p]) begin req[p] = 1'b0; granted[p]++; end
         k++;
      end
      for (int p = 0; p < 2; p++) begin
         checks++;
         if (granted[p] != issued[p]) begin
            errors++; $display("FAIL rand_grants port=%0d got=%0d exp=%0d", p, granted[p], issued[p]);
         end
      end
   endtask

   initial begin
      cyc = 0;
      for (int i = 0; i < 256; i++) mdl_mem[i] = ram_init(AW'(i));
      model_reset();
      test_reset();
      test_cpu_write();
      test_loader_read();
      test_back_to_back();
      test_late_arrival();
      test_reset_mid();
      test_both_reads();
      test_random(400);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
